// File: rtl/parking_lot_occupancy.sv
`default_nettype none
// ============================================================================
//  Module   : parking_lot_occupancy
//  Purpose  : Per-lane two-beam entry/exit FSMs feeding a shared saturating
//             occupancy counter. Optional macro PARKING_LOT_SYNC_EN adds
//             2-FF sensor synchronizers (+2 cycles of latency).
//  Revision : 1.0
// ============================================================================
module parking_lot_occupancy #(
    parameter int LANES    = 2,
    parameter int CNT_W    = 8,
    parameter int CAPACITY = 200
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [LANES-1:0] iA,
    input  logic [LANES-1:0] iB,
    input  logic             iCLR,
    output logic [LANES-1:0] oENTER,
    output logic [LANES-1:0] oEXIT,
    output logic [LANES-1:0] oERROR,
    output logic [CNT_W-1:0] oCOUNT,
    output logic             oFULL,
    output logic             oEMPTY,
    output logic             oOVF,
    output logic             oUNF
);

    localparam int SW = CNT_W + 4;
    localparam logic signed [SW-1:0] c_CAP = SW'(CAPACITY);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_EN0  = 4'd1,
        S_EN1  = 4'd2,
        S_EN2  = 4'd3,
        S_ENTD = 4'd4,
        S_EX0  = 4'd5,
        S_EX1  = 4'd6,
        S_EX2  = 4'd7,
        S_EXTD = 4'd8,
        S_ERR  = 4'd9
    } lane_state_t;

    logic [LANES-1:0] w_a;
    logic [LANES-1:0] w_b;
    logic [LANES-1:0] w_enter;
    logic [LANES-1:0] w_exit;
    logic [LANES-1:0] w_error;

`ifdef PARKING_LOT_SYNC_EN
    logic [LANES-1:0] r_a_meta;
    logic [LANES-1:0] r_a_sync;
    logic [LANES-1:0] r_b_meta;
    logic [LANES-1:0] r_b_sync;

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_a_meta <= '0;
            r_a_sync <= '0;
            r_b_meta <= '0;
            r_b_sync <= '0;
        end else begin
            r_a_meta <= iA;
            r_a_sync <= r_a_meta;
            r_b_meta <= iB;
            r_b_sync <= r_b_meta;
        end
    end

    assign w_a = r_a_sync;
    assign w_b = r_b_sync;
`else
    assign w_a = iA;
    assign w_b = iB;
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        lane_state_t r_state;
        lane_state_t w_next;
        logic [1:0]  w_ab;
        logic        w_ent;
        logic        w_ext;
        logic        w_err;

        assign w_ab = {w_a[gi], w_b[gi]};

        always_ff @(posedge iCLK or posedge iRESET) begin
            if (iRESET) r_state <= S_IDLE;
            else        r_state <= w_next;
        end

        // Codes not listed for a state hold it; terminal states ignore sensors.
        always_comb begin
            w_next = r_state;
            w_ent  = 1'b0;
            w_ext  = 1'b0;
            w_err  = 1'b0;
            case (r_state)
                S_IDLE: case (w_ab)
                    2'b10:   w_next = S_EN0;
                    2'b01:   w_next = S_EX0;
                    2'b11:   w_next = S_ERR;
                    default: w_next = r_state;
                endcase
                S_EN0: case (w_ab)
                    2'b00:   w_next = S_IDLE;
                    2'b01:   w_next = S_ERR;
                    2'b11:   w_next = S_EN1;
                    default: w_next = r_state;
                endcase
                S_EN1: case (w_ab)
                    2'b00:   w_next = S_ERR;
                    2'b01:   w_next = S_EN2;
                    2'b10:   w_next = S_EN0;
                    default: w_next = r_state;
                endcase
                S_EN2: case (w_ab)
                    2'b00:   w_next = S_ENTD;
                    2'b10:   w_next = S_ERR;
                    2'b11:   w_next = S_EN1;
                    default: w_next = r_state;
                endcase
                S_EX0: case (w_ab)
                    2'b00:   w_next = S_IDLE;
                    2'b10:   w_next = S_ERR;
                    2'b11:   w_next = S_EX1;
                    default: w_next = r_state;
                endcase
                S_EX1: case (w_ab)
                    2'b00:   w_next = S_ERR;
                    2'b10:   w_next = S_EX2;
                    2'b01:   w_next = S_EX0;
                    default: w_next = r_state;
                endcase
                S_EX2: case (w_ab)
                    2'b00:   w_next = S_EXTD;
                    2'b01:   w_next = S_ERR;
                    2'b11:   w_next = S_EX1;
                    default: w_next = r_state;
                endcase
                S_ENTD: begin
                    w_ent  = 1'b1;
                    w_next = S_IDLE;
                end
                S_EXTD: begin
                    w_ext  = 1'b1;
                    w_next = S_IDLE;
                end
                S_ERR: begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
                default: w_next = S_ERR;
            endcase
        end

        assign w_enter[gi] = w_ent;
        assign w_exit[gi]  = w_ext;
        assign w_error[gi] = w_err;
    end

    logic [CNT_W-1:0]     r_count;
    logic                 r_ovf;
    logic                 r_unf;
    logic signed [SW-1:0] w_e_cnt;
    logic signed [SW-1:0] w_x_cnt;
    logic signed [SW-1:0] w_new;

    // Wide signed sum so over/underflow are visible before saturation.
    always_comb begin
        w_e_cnt = '0;
        w_x_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_e_cnt = w_e_cnt + SW'(w_enter[i]);
            w_x_cnt = w_x_cnt + SW'(w_exit[i]);
        end
        w_new = $signed({4'b0000, r_count}) + w_e_cnt - w_x_cnt;
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (iCLR) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (w_new[SW-1]) begin
            r_count <= '0;
            r_unf   <= 1'b1;
        end else if (w_new > c_CAP) begin
            r_count <= CNT_W'(CAPACITY);
            r_ovf   <= 1'b1;
        end else begin
            r_count <= w_new[CNT_W-1:0];
        end
    end

    assign oENTER = w_enter;
    assign oEXIT  = w_exit;
    assign oERROR = w_error;
    assign oCOUNT = r_count;
    assign oFULL  = (r_count >= CNT_W'(CAPACITY));
    assign oEMPTY = (r_count == '0);
    assign oOVF   = r_ovf;
    assign oUNF   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_parking_lot_occupancy.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parking_lot_occupancy
//  Purpose  : Directed self-checking bench for parking_lot_occupancy
//             (LANES=2, CAPACITY=3).
//  Revision : 1.0
// ============================================================================
module tb_parking_lot_occupancy;

    logic       iCLK = 1'b0;
    logic       iRESET;
    logic [1:0] iA;
    logic [1:0] iB;
    logic       iCLR;
    logic [1:0] oENTER;
    logic [1:0] oEXIT;
    logic [1:0] oERROR;
    logic [7:0] oCOUNT;
    logic       oFULL;
    logic       oEMPTY;
    logic       oOVF;
    logic       oUNF;

    int checks   = 0;
    int failures = 0;

    parking_lot_occupancy #(
        .LANES    (2),
        .CNT_W    (8),
        .CAPACITY (3)
    ) u_dut (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iA     (iA),
        .iB     (iB),
        .iCLR   (iCLR),
        .oENTER (oENTER),
        .oEXIT  (oEXIT),
        .oERROR (oERROR),
        .oCOUNT (oCOUNT),
        .oFULL  (oFULL),
        .oEMPTY (oEMPTY),
        .oOVF   (oOVF),
        .oUNF   (oUNF)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and apply new sensor levels.
    task automatic tick(input logic [1:0] a, input logic [1:0] b);
        @(negedge iCLK);
        iA = a;
        iB = b;
    endtask

    task automatic enter(input logic [1:0] m);
        tick(m, 2'b00);
        tick(m, m);
        tick(2'b00, m);
        tick(2'b00, 2'b00);
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {26'd0, oENTER, oEXIT, oERROR}, 32'd0);
    endtask

    initial begin
        iRESET = 1'b1;
        iA     = 2'b00;
        iB     = 2'b00;
        iCLR   = 1'b0;
        repeat (2) @(negedge iCLK);
        chk("rst_count", 32'(oCOUNT), 32'd0);
        chk("rst_flags", {28'd0, oFULL, oEMPTY, oOVF, oUNF}, 32'b0100);
        chk_quiet("rst_pulses");
        iRESET = 1'b0;

        // Lane 0 entry: pulse one cycle after final 00, count on next edge.
        enter(2'b01);
        tick(2'b00, 2'b00);
        chk("entry_pulse", {30'd0, oENTER}, 32'b01);
        chk("entry_cnt_before", 32'(oCOUNT), 32'd0);
        tick(2'b00, 2'b00);
        chk("entry_pulse_gone", {30'd0, oENTER}, 32'b00);
        chk("entry_cnt", 32'(oCOUNT), 32'd1);
        chk("entry_empty", 32'(oEMPTY), 32'd0);

        // Lane 1 exit: 01,11,10,00.
        tick(2'b00, 2'b10);
        tick(2'b10, 2'b10);
        tick(2'b10, 2'b00);
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        chk("exit_pulse", {30'd0, oEXIT}, 32'b10);
        tick(2'b00, 2'b00);
        chk("exit_cnt", 32'(oCOUNT), 32'd0);
        chk("exit_flags", {28'd0, oFULL, oEMPTY, oOVF, oUNF}, 32'b0100);

        // Back-out 10,00: no pulse.
        tick(2'b01, 2'b00);
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        chk_quiet("backout_pulses");
        tick(2'b00, 2'b00);
        chk_quiet("backout_pulses2");
        chk("backout_cnt", 32'(oCOUNT), 32'd0);

        // 10,01 on lane 0: one-cycle error.
        tick(2'b01, 2'b00);
        tick(2'b00, 2'b01);
        tick(2'b00, 2'b00);
        chk("err_pulse", {30'd0, oERROR}, 32'b01);
        tick(2'b00, 2'b00);
        chk("err_gone", {30'd0, oERROR}, 32'b00);
        chk("err_cnt", 32'(oCOUNT), 32'd0);

        // Fill to capacity, then overflow.
        repeat (3) begin
            enter(2'b01);
            tick(2'b00, 2'b00);
        end
        tick(2'b00, 2'b00);
        chk("full_cnt", 32'(oCOUNT), 32'd3);
        chk("full_flags", {28'd0, oFULL, oEMPTY, oOVF, oUNF}, 32'b1000);
        enter(2'b01);
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        chk("ovf_cnt", 32'(oCOUNT), 32'd3);
        chk("ovf_flags", {28'd0, oFULL, oEMPTY, oOVF, oUNF}, 32'b1010);

        // Clear.
        @(negedge iCLK);
        iCLR = 1'b1;
        @(negedge iCLK);
        iCLR = 1'b0;
        chk("clr_cnt", 32'(oCOUNT), 32'd0);
        chk("clr_flags", {28'd0, oFULL, oEMPTY, oOVF, oUNF}, 32'b0100);

        // Count to 2, then simultaneous lane0 entry + lane1 exit.
        repeat (2) begin
            enter(2'b01);
            tick(2'b00, 2'b00);
        end
        tick(2'b00, 2'b00);
        chk("two_cnt", 32'(oCOUNT), 32'd2);
        tick(2'b01, 2'b10);
        tick(2'b11, 2'b11);
        tick(2'b10, 2'b01);
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        chk("simul_pulses", {28'd0, oENTER, oEXIT}, 32'b0110);
        tick(2'b00, 2'b00);
        chk("simul_cnt2", 32'(oCOUNT), 32'd2);
        chk("simul_flags2", {28'd0, oFULL, oEMPTY, oOVF, oUNF}, 32'b0000);

        // Same event at count 0: no underflow.
        @(negedge iCLK);
        iCLR = 1'b1;
        @(negedge iCLK);
        iCLR = 1'b0;
        tick(2'b01, 2'b10);
        tick(2'b11, 2'b11);
        tick(2'b10, 2'b01);
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        chk("simul_cnt0", 32'(oCOUNT), 32'd0);
        chk("simul_flags0", {28'd0, oFULL, oEMPTY, oOVF, oUNF}, 32'b0100);

        // Lone exit at count 0 sets sticky underflow.
        tick(2'b00, 2'b10);
        tick(2'b10, 2'b10);
        tick(2'b10, 2'b00);
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        chk("unf_cnt", 32'(oCOUNT), 32'd0);
        chk("unf_flags", {28'd0, oFULL, oEMPTY, oOVF, oUNF}, 32'b0101);

        // Async reset while lane 0 sits in EN1 after one entry.
        enter(2'b01);
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        chk("pre_rst_cnt", 32'(oCOUNT), 32'd1);
        tick(2'b01, 2'b00);
        tick(2'b01, 2'b01);
        @(negedge iCLK);
        iRESET = 1'b1;
        #1;
        chk("arst_cnt", 32'(oCOUNT), 32'd0);
        chk("arst_flags", {28'd0, oFULL, oEMPTY, oOVF, oUNF}, 32'b0100);
        chk_quiet("arst_pulses");
        @(negedge iCLK);
        iRESET = 1'b0;
        iA     = 2'b00;
        iB     = 2'b01;
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        chk_quiet("post_rst_q1");
        tick(2'b00, 2'b00);
        chk_quiet("post_rst_q2");
        chk("post_rst_cnt", 32'(oCOUNT), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parking_lot_occupancy.md
Name: parking_lot_occupancy

Overview:
- Multi-lane parking lot controller. Each of LANES gates has a two-beam sensor pair (A outer, B inner) and its own entry/exit/error sequence FSM.
- Per-lane completed entries and exits feed a shared saturating occupancy counter with full/empty status and sticky overflow/underflow flags.
- Sits between the gate sensor front-end and the lot display/barrier logic.

Parameters:
- LANES, 2, number of independent gate lanes (1..8).
- CNT_W, 8, occupancy counter width.
- CAPACITY, 200, lot capacity; must be < 2**CNT_W.

Ports:
- iCLK  input  1  system clock, rising edge.
- iRESET  input  1  asynchronous, active-high reset.
- iA  input  LANES  outer beam blocked per lane, bit i = lane i.
- iB  input  LANES  inner beam blocked per lane.
- iCLR  input  1  synchronous clear: count to 0, sticky flags cleared.
- oENTER  output  LANES  one-cycle pulse per completed entry.
- oEXIT  output  LANES  one-cycle pulse per completed exit.
- oERROR  output  LANES  one-cycle pulse per illegal sensor sequence.
- oCOUNT  output  CNT_W  current occupancy.
- oFULL  output  1  oCOUNT >= CAPACITY.
- oEMPTY  output  1  oCOUNT == 0.
- oOVF  output  1  sticky: entry while full.
- oUNF  output  1  sticky: exit while empty.

Behaviour:
- Reset: all lane FSMs IDLE; oCOUNT=0, oOVF=oUNF=0, oENTER/oEXIT/oERROR=0, oEMPTY=1, oFULL=0.
- Each lane FSM is Moore and registered. {A,B} is sampled each clock. Unlisted codes hold state.
  - IDLE: 10→EN0, 01→EX0, 11→ERR.
  - EN0: 00→IDLE, 01→ERR, 11→EN1.
  - EN1: 00→ERR, 01→EN2, 10→EN0.
  - EN2: 00→ENTD, 10→ERR, 11→EN1.
  - EX0: 00→IDLE, 10→ERR, 11→EX1.
  - EX1: 00→ERR, 10→EX2, 01→EX0.
  - EX2: 00→EXTD, 01→ERR, 11→EX1.
  - ENTD, EXTD and ERR each last exactly one cycle and assert oENTER[i], oEXIT[i] and oERROR[i] respectively, then go to IDLE unconditionally. Sensor input during that cycle is ignored.
  - Any illegal encoding: treated as ERR.
- Latency: the final 00 is sampled at edge k; the lane pulse is high from edge k to k+1; oCOUNT updates at edge k+1.
- Counter arithmetic, per cycle:
  - E = popcount(oENTER), X = popcount(oEXIT); new = count + E − X, computed at width CNT_W+4, signed.
  - If new > CAPACITY: count = CAPACITY and oOVF set.
  - If new < 0: count = 0 and oUNF set.
  - Simultaneous entry and exit on different lanes cancel; no flag is set if the net result is in range.
- oFULL and oEMPTY are combinational from oCOUNT.
- iCLR has priority over the counter update in the same cycle. Lane FSMs are unaffected by iCLR.
- Asynchronous reset mid-sequence aborts all lanes immediately; no pulses are emitted.
- Lanes are fully independent. Errors on one lane do not affect the others or the count.

Optional Feature:
- Macro: PARKING_LOT_SYNC_EN.
- Defined: iA and iB pass through 2-FF synchronizers per lane, reset to 0, before the FSMs. All sensor-to-pulse latencies grow by 2 cycles.
- Undefined: the FSMs sample iA/iB directly, as specified above.

Test Plan:
- LANES=2, lane 0 drives 10,11,01,00 for one cycle each → oENTER[0] pulses once, 1 cycle after 00 is sampled; oCOUNT 0→1 on the next edge; oEMPTY falls.
- Lane 1 drives 01,11,10,00 from count=1 → oEXIT[1] pulses once; oCOUNT=0; oEMPTY=1; oUNF stays 0.
- Lane 0 drives 10,00 (car backs out) → no pulses, count unchanged. Lane 0 drives 10,01 → oERROR[0] one cycle, then IDLE.
- CAPACITY=3: four entries → oCOUNT saturates at 3, oFULL=1, oOVF=1. iCLR → oCOUNT=0, oOVF=0.
- Lane 0 entry and lane 1 exit complete in the same cycle at count=2 → oCOUNT stays 2, no flags. At count=0 the same event gives count 0 and no oUNF.
- Assert iRESET while lane 0 is in EN1 → all outputs at reset values. Sequence 01,00 after release → returns to IDLE with no pulse. With PARKING_LOT_SYNC_EN defined, the first scenario's pulse arrives 2 cycles later.
